sseg_scan_decoder: RTL

Receive-side counterpart of the multiplexed seven-segment driver. Samples the scanned `sseg`/`AN` bus, decodes each digit's segment pattern back to a hex nibble, and publishes a complete, double-buffered 8-digit snapshot once every anode has been captured. It is used as an on-chip self-check monitor and as the scoreboard front-end in display benches.

---
 rtl/sseg_scan_decoder.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/sseg_scan_decoder.sv
// sseg_scan_decoder
//   Receive-side monitor for a multiplexed seven-segment display bus. Samples
//   the scanned sseg/AN lines and waits for each anode to settle. It decodes
//   each digit's segment pattern back to a hex nibble and publishes a
//   double-buffered 8-digit snapshot once every anode has been captured.
//
// Parameters
//   SETTLE       stable cycles required before a digit is captured (1..255)
// Ports
//   sysclk       system clock, rising edge
//   rst          asynchronous reset, active low
//   sseg[7:0]    segment bus, active low; [6:0] = g..a, [7] = dp
//   AN[7:0]      anode enables, active low; bit i selects digit i
//   digits[31:0] published nibbles, digit i at [4i+3:4i]
//   dp[7:0]      published decimal points, active high
//   blank[7:0]   digit i had all segments off
//   bad[7:0]     digit i had a pattern outside the decode table
//   frame_valid  one-cycle pulse when the published outputs update
//   err_an       one-cycle pulse on entry to an illegal AN value
module sseg_scan_decoder #(
    parameter int unsigned SETTLE = 4
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic [7:0]  sseg,
    input  logic [7:0]  AN,
    output logic [31:0] digits,
    output logic [7:0]  dp,
    output logic [7:0]  blank,
    output logic [7:0]  bad,
    output logic        frame_valid,
    output logic        err_an
);

    localparam logic [7:0] SETTLE_W = 8'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } state_t;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;

    logic [7:0]  s_r, a_r, s_p, a_p;

    logic [31:0] sh_digits;
    logic [7:0]  sh_dp, sh_blank, sh_bad;
    logic [7:0]  seen, seen_n;

    logic [2:0]  an_idx;
    logic [3:0]  an_zeros;
    logic        an_off, an_valid, an_ill;
    logic        changed;
    logic        cap;

    logic [6:0]  p;
    logic [3:0]  dec_nib;
    logic        dec_blank, dec_bad;

    // Anode classification: off, exactly one active anode, or illegal.
    always_comb begin
        an_idx   = '0;
        an_zeros = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!a_r[i]) begin
                an_idx   = 3'(i);
                an_zeros = an_zeros + 4'd1;
            end
        end
        an_off   = (a_r == 8'hFF);
        an_valid = (an_zeros == 4'd1);
        an_ill   = !an_off && !an_valid;
    end

    assign changed = (a_r != a_p) || (s_r != s_p);

    // Segment pattern back to nibble; the bus is active low.
    assign p = ~s_r[6:0];

    always_comb begin
        dec_nib   = '0;
        dec_blank = 1'b0;
        dec_bad   = 1'b0;
        case (p)
            7'h3F: dec_nib = 4'h0;
            7'h06: dec_nib = 4'h1;
            7'h5B: dec_nib = 4'h2;
            7'h4F: dec_nib = 4'h3;
            7'h66: dec_nib = 4'h4;
            7'h6D: dec_nib = 4'h5;
            7'h7D: dec_nib = 4'h6;
            7'h07: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h6F: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h7C: dec_nib = 4'hB;
            7'h39: dec_nib = 4'hC;
            7'h5E: dec_nib = 4'hD;
            7'h79: dec_nib = 4'hE;
            7'h71: dec_nib = 4'hF;
            7'h00: dec_blank = 1'b1;
            default: dec_bad = 1'b1;
        endcase
    end

    // Capture fires on the first stable cycle after cnt has already reached
    // SETTLE, so an anode must dwell SETTLE+1 cycles to be taken.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cap     = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (an_valid) begin
                    state_n = ST_SETTLE;
                    cnt_n   = 8'd1;
                end
            end
            ST_SETTLE: begin
                if (changed) begin
                    if (an_valid) begin
                        cnt_n = 8'd1;
                    end else begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end
                end else if (cnt >= SETTLE_W) begin
                    cap     = 1'b1;
                    state_n = ST_HOLD;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            ST_HOLD: begin
                if (changed) begin
                    if (an_valid) begin
                        state_n = ST_SETTLE;
                        cnt_n   = 8'd1;
                    end else begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // A completed mask is cleared in the same cycle it is published; a
    // coincident capture still lands in the fresh mask.
    always_comb begin
        seen_n = (seen == 8'hFF) ? 8'h00 : seen;
        if (cap) begin
            seen_n[an_idx] = 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            s_r         <= '1;
            a_r         <= '1;
            s_p         <= '1;
            a_p         <= '1;
            sh_digits   <= '0;
            sh_dp       <= '0;
            sh_blank    <= '0;
            sh_bad      <= '0;
            seen        <= '0;
            digits      <= '0;
            dp          <= '0;
            blank       <= '0;
            bad         <= '0;
            frame_valid <= 1'b0;
            err_an      <= 1'b0;
        end else begin
            s_r         <= sseg;
            a_r         <= AN;
            s_p         <= s_r;
            a_p         <= a_r;
            err_an      <= an_ill && (a_r != a_p);
            frame_valid <= 1'b0;
            seen        <= seen_n;
            if (cap) begin
                sh_digits[{an_idx, 2'b00} +: 4] <= dec_nib;
                sh_dp[an_idx]                   <= ~s_r[7];
                sh_blank[an_idx]                <= dec_blank;
                sh_bad[an_idx]                  <= dec_bad;
            end
            if (seen == 8'hFF) begin
                digits      <= sh_digits;
                dp          <= sh_dp;
                blank       <= sh_blank;
                bad         <= sh_bad;
                frame_valid <= 1'b1;
            end
        end
    end

endmodule
